// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: redirect-type encodings,
// the default trap vector and the slot record held in the fetch ring.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] DEFAULT_VECTOR = 32'h0000_0040;

  typedef enum logic [1:0] {
    PCSEL_IMD   = 2'b00,
    PCSEL_REGA  = 2'b01,
    PCSEL_INDEX = 2'b10,
    PCSEL_VEC   = 2'b11
  } pcsel_e;

  // One ring entry; data fields are sized for FETCH_XLEN.
  typedef struct packed {
    logic                  busy;
    logic                  filled;
    logic [FETCH_XLEN-1:0] nextpc;
    logic [FETCH_XLEN-1:0] instr;
  } slot_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundles the instruction-memory port, the decode handshake and the redirect
// inputs of the fetch buffer; master is the fetch side, slave the environment.
interface fetch_buffer_if
  import fetch_pkg::*;
#(
  parameter int XLEN    = FETCH_XLEN,
  parameter int IADDR_W = 7
) ();

  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [XLEN-1:0]    imem_rdata;

  logic               id_stall;
  logic               if_id_valid;
  logic [XLEN-1:0]    if_id_instruc;
  logic [XLEN-1:0]    if_id_nextpc;

  logic               id_if_selpcsource;
  logic [1:0]         id_if_selpctype;
  logic [XLEN-1:0]    id_if_rega;
  logic [XLEN-1:0]    id_if_pcimd2ext;
  logic [XLEN-1:0]    id_if_pcindex;
  logic               fetch_misalign;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  id_stall,
    output if_id_valid, if_id_instruc, if_id_nextpc,
    input  id_if_selpcsource, id_if_selpctype, id_if_rega, id_if_pcimd2ext, id_if_pcindex,
    output fetch_misalign
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output id_stall,
    input  if_id_valid, if_id_instruc, if_id_nextpc,
    output id_if_selpcsource, id_if_selpctype, id_if_rega, id_if_pcimd2ext, id_if_pcindex,
    input  fetch_misalign
  );

endinterface

// File: rtl/fetch_slot_ring.sv
// Ring of fetch slots with independent allocate (tail), fill and dequeue (head)
// pointers; flush clears every slot and rewinds all pointers.
module fetch_slot_ring
  import fetch_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             allocate,
  input  logic [XLEN-1:0]  alloc_nextpc,
  input  logic             fill,
  input  logic [XLEN-1:0]  fill_data,
  input  logic             dequeue,
  input  logic             flush,
  output logic             full,
  output logic [CNT_W-1:0] unfilled_cnt,
  output logic             head_valid,
  output logic [XLEN-1:0]  head_instr,
  output logic [XLEN-1:0]  head_nextpc
);

  localparam int PTR_W = $clog2(DEPTH);

  slot_t            slots [DEPTH];
  logic [PTR_W-1:0] tail_ptr, fill_ptr, head_ptr;
  logic [CNT_W-1:0] busy_cnt;

  always_comb begin
    busy_cnt     = '0;
    unfilled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt     = busy_cnt + CNT_W'(slots[i].busy);
      unfilled_cnt = unfilled_cnt + CNT_W'(slots[i].busy & ~slots[i].filled);
    end
  end

  assign full        = (busy_cnt == CNT_W'(DEPTH));
  assign head_valid  = slots[head_ptr].busy & slots[head_ptr].filled;
  assign head_instr  = XLEN'(slots[head_ptr].instr);
  assign head_nextpc = XLEN'(slots[head_ptr].nextpc);

  // Allocate, fill and dequeue never touch the same slot in one cycle, so
  // their field updates can be issued independently.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
    end else begin
      if (allocate) begin
        slots[tail_ptr].busy   <= 1'b1;
        slots[tail_ptr].filled <= 1'b0;
        slots[tail_ptr].nextpc <= FETCH_XLEN'(alloc_nextpc);
        tail_ptr               <= tail_ptr + PTR_W'(1);
      end
      if (fill) begin
        slots[fill_ptr].filled <= 1'b1;
        slots[fill_ptr].instr  <= FETCH_XLEN'(fill_data);
        fill_ptr               <= fill_ptr + PTR_W'(1);
      end
      if (dequeue) begin
        slots[head_ptr].busy   <= 1'b0;
        slots[head_ptr].filled <= 1'b0;
        head_ptr               <= head_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: PC generation, redirect/flush with stale-response
// dropping, and a slot ring feeding decode. FETCH_ALIGN_CHECK_EN enables traps
// on misaligned redirect targets.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 4,
  parameter int              IADDR_W = 7,
  parameter logic [XLEN-1:0] VECTOR  = XLEN'(DEFAULT_VECTOR)
) (
  input logic            clock,
  input logic            reset,
  fetch_buffer_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc, pc_plus4, target_raw, target;
  logic [CNT_W-1:0] drop_cnt, unfilled_cnt;
  logic             redirect, ring_full, req, accept, fill_en, dequeue, head_valid;

  assign redirect = bus.id_if_selpcsource;
  assign pc_plus4 = pc + XLEN'(4);
  assign req      = ~reset & ~redirect & ~ring_full;
  assign accept   = req & bus.imem_ready;
  assign fill_en  = bus.imem_rvalid & (drop_cnt == '0) & ~redirect;
  assign dequeue  = head_valid & ~bus.id_stall & ~redirect;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc[IADDR_W+1:2];
  assign bus.if_id_valid = head_valid;

  always_comb begin
    target_raw = bus.id_if_pcimd2ext;
    case (pcsel_e'(bus.id_if_selpctype))
      PCSEL_REGA:  target_raw = bus.id_if_rega;
      PCSEL_INDEX: target_raw = bus.id_if_pcindex;
      PCSEL_VEC:   target_raw = VECTOR;
      default:     target_raw = bus.id_if_pcimd2ext;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned, misalign_q;

  assign misaligned         = (target_raw[1:0] != 2'b00);
  assign target             = misaligned ? VECTOR : target_raw;
  assign bus.fetch_misalign = misalign_q;

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= redirect & misaligned;
  end
`else
  assign target             = target_raw & ~XLEN'(3);
  assign bus.fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)         pc <= '0;
    else if (redirect) pc <= target;
    else if (accept)   pc <= pc_plus4;
  end

  // Requests still in flight at a redirect are counted so their responses can
  // be discarded; one arriving in the redirect cycle itself is already gone.
  always_ff @(posedge clock) begin
    if (reset)
      drop_cnt <= '0;
    else if (redirect)
      drop_cnt <= unfilled_cnt - CNT_W'(bus.imem_rvalid && (drop_cnt == '0));
    else if (bus.imem_rvalid && (drop_cnt != '0))
      drop_cnt <= drop_cnt - CNT_W'(1);
  end

  fetch_slot_ring #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clock        (clock),
    .reset        (reset),
    .allocate     (accept),
    .alloc_nextpc (pc_plus4),
    .fill         (fill_en),
    .fill_data    (bus.imem_rdata),
    .dequeue      (dequeue),
    .flush        (redirect),
    .full         (ring_full),
    .unfilled_cnt (unfilled_cnt),
    .head_valid   (head_valid),
    .head_instr   (bus.if_id_instruc),
    .head_nextpc  (bus.if_id_nextpc)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer with an in-order instruction
// memory model of programmable latency.
module tb_fetch_buffer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 1;
  int   acc_count = 0;
  logic last_reset = 1'b1;
  int          due_q [$];
  logic [6:0]  addr_q [$];

  fetch_buffer_if bus ();

  fetch_buffer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [31:0] mem_word(input logic [6:0] a);
    return 32'hC0DE_0000 | {25'd0, a};
  endfunction

  // Memory model: answers in order after mem_lat cycles; anything still queued
  // when reset deasserts is discarded.
  always @(negedge clock) begin
    if (!reset && last_reset) begin
      due_q.delete();
      addr_q.delete();
    end
    last_reset = reset;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(addr_q[0]);
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end
    if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin
      due_q.push_back(cyc + mem_lat);
      addr_q.push_back(bus.imem_addr);
      acc_count++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic stall);
    reset = 1'b1;
    bus.id_if_selpcsource = 1'b0;
    bus.id_stall = stall;
    mem_lat = lat;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", bus.imem_req); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus.if_id_valid); end
    checks++; if (bus.if_id_instruc !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", bus.if_id_instruc); end
    checks++; if (bus.if_id_nextpc !== 32'h0) begin errors++; $display("[TB] FAIL reset_nextpc got %h want 0", bus.if_id_nextpc); end
    checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b want 0", bus.fetch_misalign); end
    checks++; if (bus.imem_addr !== 7'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_streaming();
    do_reset(1, 1'b0);
    tick();
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_empty got %b want 0", bus.if_id_valid); end
    tick();
    for (int k = 1; k <= 7; k++) begin
      checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %b want 1", k, bus.if_id_valid); end
      checks++; if (bus.if_id_nextpc !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_nextpc[%0d] got %h want %h", k, bus.if_id_nextpc, 32'(4 * k)); end
      checks++; if (bus.if_id_instruc !== mem_word(7'(k - 1))) begin errors++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", k, bus.if_id_instruc, mem_word(7'(k - 1))); end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    int start;
    do_reset(1, 1'b1);
    start = acc_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_nextpc !== 32'h4) begin
          errors++; $display("[TB] FAIL stall_hold[%0d] got valid %b nextpc %h want 1 00000004", i, bus.if_id_valid, bus.if_id_nextpc);
        end
      end
    end
    checks++; if (acc_count - start !== 4) begin errors++; $display("[TB] FAIL stall_req_count got %0d want 4", acc_count - start); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_full got %b want 0", bus.imem_req); end
    checks++; if (bus.if_id_instruc !== mem_word(7'h0)) begin errors++; $display("[TB] FAIL stall_instr got %h want %h", bus.if_id_instruc, mem_word(7'h0)); end
    bus.id_stall = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_dequeue_req got %b want 0", bus.imem_req); end
    tick();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_nextpc !== 32'h8) begin errors++; $display("[TB] FAIL stall_release got valid %b nextpc %h want 1 00000008", bus.if_id_valid, bus.if_id_nextpc); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_req got %b want 1", bus.imem_req); end
  endtask

  task automatic test_redirect_inflight();
    int  n;
    do_reset(3, 1'b0);
    tick();
    tick();
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b01;
    bus.id_if_rega        = 32'h100;
    bus.id_if_pcimd2ext   = 32'h300;
    bus.id_if_pcindex     = 32'h500;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_blocked got %b want 0", bus.imem_req); end
    tick();
    bus.id_if_selpcsource = 1'b0;
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid_after got %b want 0", bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 7'h40) begin errors++; $display("[TB] FAIL redir_addr got %h want 40", bus.imem_addr); end
    n = 0;
    while (bus.if_id_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("[TB] FAIL redir_timeout got %0d cycles want <20", n); end
    checks++; if (bus.if_id_nextpc !== 32'h104) begin errors++; $display("[TB] FAIL redir_nextpc got %h want 00000104", bus.if_id_nextpc); end
    checks++; if (bus.if_id_instruc !== mem_word(7'h40)) begin errors++; $display("[TB] FAIL redir_instr got %h want %h", bus.if_id_instruc, mem_word(7'h40)); end
  endtask

  task automatic test_trap();
    do_reset(1, 1'b0);
    tick();
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b11;
    bus.id_if_rega        = 32'h180;
    bus.id_if_pcimd2ext   = 32'h1C0;
    bus.id_if_pcindex     = 32'h0C0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL trap_req_blocked got %b want 0", bus.imem_req); end
    tick();
    bus.id_if_selpcsource = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 7'h10) begin errors++; $display("[TB] FAIL trap_request got req %b addr %h want 1 10", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_valid_t1 got %b want 0", bus.if_id_valid); end
    tick();
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_valid_t2 got %b want 0", bus.if_id_valid); end
    tick();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_nextpc !== 32'h44) begin errors++; $display("[TB] FAIL trap_out got valid %b nextpc %h want 1 00000044", bus.if_id_valid, bus.if_id_nextpc); end
    checks++; if (bus.if_id_instruc !== mem_word(7'h10)) begin errors++; $display("[TB] FAIL trap_instr got %h want %h", bus.if_id_instruc, mem_word(7'h10)); end
  endtask

  task automatic test_redirect_types();
    logic [31:0] tgt [3];
    logic [6:0]  exp_addr [3];
    tgt[0] = 32'h120; exp_addr[0] = 7'h48;
    tgt[1] = 32'h0B0; exp_addr[1] = 7'h2C;
    tgt[2] = 32'h1FC; exp_addr[2] = 7'h7F;
    for (int t = 0; t < 3; t++) begin
      do_reset(1, 1'b0);
      bus.id_if_pcimd2ext   = tgt[0];
      bus.id_if_rega        = tgt[1];
      bus.id_if_pcindex     = tgt[2];
      bus.id_if_selpctype   = 2'(t);
      bus.id_if_selpcsource = 1'b1;
      tick();
      bus.id_if_selpcsource = 1'b0;
      #1;
      checks++; if (bus.imem_addr !== exp_addr[t]) begin errors++; $display("[TB] FAIL sel%0d_addr got %h want %h", t, bus.imem_addr, exp_addr[t]); end
      tick();
      tick();
      checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_nextpc !== tgt[t] + 32'd4) begin errors++; $display("[TB] FAIL sel%0d_out got valid %b nextpc %h want 1 %h", t, bus.if_id_valid, bus.if_id_nextpc, tgt[t] + 32'd4); end
      checks++; if (bus.if_id_instruc !== mem_word(exp_addr[t])) begin errors++; $display("[TB] FAIL sel%0d_instr got %h want %h", t, bus.if_id_instruc, mem_word(exp_addr[t])); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_np;
    logic [6:0]  exp_a;
    logic        exp_flag;
    do_reset(1, 1'b0);
    bus.id_if_selpctype = 2'b00;
`ifdef FETCH_ALIGN_CHECK_EN
    bus.id_if_pcimd2ext = 32'h202;
    exp_np = 32'h44; exp_a = 7'h10; exp_flag = 1'b1;
`else
    bus.id_if_pcimd2ext = 32'h0F2;
    exp_np = 32'hF4; exp_a = 7'h3C; exp_flag = 1'b0;
`endif
    bus.id_if_selpcsource = 1'b1;
    tick();
    bus.id_if_selpcsource = 1'b0;
    #1;
    checks++; if (bus.fetch_misalign !== exp_flag) begin errors++; $display("[TB] FAIL misalign_pulse got %b want %b", bus.fetch_misalign, exp_flag); end
    checks++; if (bus.imem_addr !== exp_a) begin errors++; $display("[TB] FAIL misalign_addr got %h want %h", bus.imem_addr, exp_a); end
    tick();
    checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("[TB] FAIL misalign_clear got %b want 0", bus.fetch_misalign); end
    tick();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_nextpc !== exp_np) begin errors++; $display("[TB] FAIL misalign_out got valid %b nextpc %h want 1 %h", bus.if_id_valid, bus.if_id_nextpc, exp_np); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(3, 1'b1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req got %b want 0", bus.imem_req); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", bus.if_id_valid); end
    checks++; if (bus.imem_addr !== 7'h0) begin errors++; $display("[TB] FAIL rstmid_addr got %h want 0", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_req_after got %b want 1", bus.imem_req); end
    tick();
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid_next got %b want 0", bus.if_id_valid); end
    n = 0;
    while (bus.if_id_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("[TB] FAIL rstmid_timeout got %0d cycles want <20", n); end
    checks++; if (bus.if_id_nextpc !== 32'h4 || bus.if_id_instruc !== mem_word(7'h0)) begin errors++; $display("[TB] FAIL rstmid_out got nextpc %h instr %h want 00000004 %h", bus.if_id_nextpc, bus.if_id_instruc, mem_word(7'h0)); end
  endtask

  initial begin
    bus.imem_ready        = 1'b1;
    bus.id_stall          = 1'b0;
    bus.id_if_selpcsource = 1'b0;
    bus.id_if_selpctype   = 2'b00;
    bus.id_if_rega        = '0;
    bus.id_if_pcimd2ext   = '0;
    bus.id_if_pcindex     = '0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_redirect_inflight();
    test_trap();
    test_redirect_types();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of slots; legal values are powers of 2 that are at least 2.
REQ-003 SHALL have parameter IADDR_W, default 7, meaning the instruction-memory word-address width.
REQ-004 SHALL have parameter VECTOR, default 32'h0000_0040, meaning the trap target.
REQ-005 SHALL have port clock, input, 1 bit: the single clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset that is synchronous and active-high.
REQ-007 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-008 SHALL have port imem_addr, output, IADDR_W bits: equal to pc[IADDR_W+1:2].
REQ-009 SHALL have port imem_ready, input, 1 bit: the request is accepted when imem_req and imem_ready are both high.
REQ-010 SHALL have port imem_rvalid, input, 1 bit: response valid; responses arrive in order with latency of 1 or more cycles.
REQ-011 SHALL have port imem_rdata, input, XLEN bits: instruction word.
REQ-012 SHALL have port id_stall, input, 1 bit: decode cannot accept.
REQ-013 SHALL have port if_id_valid, output, 1 bit: the head slot holds an instruction.
REQ-014 SHALL have port if_id_instruc, output, XLEN bits: the head instruction.
REQ-015 SHALL have port if_id_nextpc, output, XLEN bits: the head instruction's PC+4.
REQ-016 SHALL have port id_if_selpcsource, input, 1 bit: redirect strobe.
REQ-017 SHALL have port id_if_selpctype, input, 2 bits: redirect type; 00 selects pcimd2ext, 01 selects rega, 10 selects pcindex, 11 selects VECTOR.
REQ-018 SHALL have ports id_if_rega, id_if_pcimd2ext and id_if_pcindex, each input, XLEN bits: the redirect targets.
REQ-019 SHALL have port fetch_misalign, output, 1 bit: one-cycle misaligned-redirect flag.

Function
REQ-020 SHALL keep a ring of DEPTH slots, each holding {busy, filled, nextpc, instr}, with three pointers:
- tail: allocates a slot on request acceptance.
- fill: fills the oldest busy, unfilled slot on response.
- head: presents the output.
REQ-021 SHALL assert imem_req when all three hold:
- reset is low;
- id_if_selpcsource is low;
- fewer than DEPTH slots are busy.
REQ-022 SHALL, on request acceptance, write pc+4 into the tail slot's nextpc, set busy, advance tail, and set pc to pc+4.
REQ-023 SHALL, when imem_rvalid is high and drop_cnt is 0, write imem_rdata into the fill slot, set filled, and advance fill.
REQ-024 SHALL drive if_id_valid from busy&filled of the head slot, and drive if_id_instruc and if_id_nextpc combinationally from the head slot.
REQ-025 SHALL dequeue the head when if_id_valid is high and id_stall is low, clearing busy and advancing head; while id_stall is high, the outputs SHALL hold stable.
REQ-026 SHALL let allocation, fill and dequeue occur in the same cycle; with DEPTH slots busy and a dequeue, the request is still withheld that cycle because fullness is evaluated from registered state.
REQ-027 SHALL, on a redirect (id_if_selpcsource high):
- load pc with the selected target;
- clear all slots and reset all pointers to 0;
- load drop_cnt with (busy-but-unfilled count) minus (1 if imem_rvalid is high that cycle and drop_cnt is 0);
- issue no request that cycle.
REQ-028 SHALL, while drop_cnt is greater than 0, discard each imem_rvalid response and decrement drop_cnt; drop_cnt SHALL be $clog2(DEPTH+1) bits wide.
REQ-029 SHALL give redirect priority over dequeue and fill in the same cycle; if_id_valid SHALL be 0 in the cycle after a redirect.
REQ-030 SHALL meet this latency with imem_ready tied high and 1-cycle read latency: redirect at cycle t gives a request at t+1, a response at t+2, and if_id_valid high at t+3.
REQ-031 SHALL wrap pc modulo 2^XLEN and wrap all pointers modulo DEPTH.

Reset
REQ-032 SHALL, while reset is high at a clock edge, set:
- pc to 0;
- all slots, pointers and drop_cnt to 0;
- imem_req to 0, if_id_valid to 0, if_id_instruc to 0, if_id_nextpc to 0 and fetch_misalign to 0.
REQ-033 SHALL discard pending responses after a reset asserted mid-fetch; responses received while reset is high are ignored, and the environment SHALL not deliver pre-reset responses after reset deasserts.

Configuration
REQ-034 SHALL, when FETCH_ALIGN_CHECK_EN is defined, treat a redirect target with bits [1:0] not equal to 00 as follows:
- load pc with VECTOR instead;
- pulse fetch_misalign for the following cycle;
- flush exactly as in REQ-027.
REQ-035 SHALL, when FETCH_ALIGN_CHECK_EN is undefined, force target bits [1:0] to 00 and tie fetch_misalign to 0.

Structure
REQ-036 SHALL place the selpctype encodings (PCSEL_IMD, PCSEL_REGA, PCSEL_INDEX, PCSEL_VEC), the default VECTOR and the slot record type in package fetch_pkg.
REQ-037 SHALL implement the slot ring as sub-module fetch_slot_ring, with allocate, fill, dequeue and flush ports; PC and target selection SHALL stay in fetch_buffer.

Verification
REQ-038 SHALL cover streaming: imem has 1-cycle latency and id_stall=0 from reset; if_id_nextpc runs 4, 8, 12, and so on, one per cycle from cycle 3.
REQ-039 SHALL cover stall fill: id_stall=1 for 10 cycles; exactly DEPTH=4 requests, then imem_req=0; outputs stay at nextpc=4.
REQ-040 SHALL cover redirect with in-flight requests: 3-cycle imem latency and selpctype=01 with rega=32'h100 while 2 requests are unfilled; 2 responses are dropped, and the next valid output has nextpc=32'h104.
REQ-041 SHALL cover trap redirect: selpctype=11; the next request has imem_addr=7'h10, and the output has nextpc=32'h44.
REQ-042 SHALL cover the misalign check when FETCH_ALIGN_CHECK_EN is defined: pcimd2ext=32'h202 with type 00 gives a 1-cycle fetch_misalign pulse and a fetch from VECTOR.
REQ-043 SHALL cover reset mid-operation: reset pulsed with 3 slots busy; the cycle after deassertion, if_id_valid=0 and imem_addr=0.
